// File: rtl/snk_game_ctrl.sv
// rtl/snk_game_ctrl.sv - game sequencer for the snake datapath
// Generates the move strobe, filters direction input against reversal,
// places food from an LFSR, detects eating, tracks score and game state.
// Ports:
//   CLK, rst_n        clock, asynchronous active-low reset
//   btn_dir/btn_valid requested direction and its one-cycle qualifier
//   btn_start         one-cycle start/restart strobe
//   snk_head          snake head {on,x,y}, valid the cycle after snk_step
//   snk_dead          snake collision flag
//   snk_dir           committed direction to the snake
//   snk_step          one-cycle move enable to the snake
//   snk_rst           active-high restart to the snake (high in IDLE)
//   score             current score / snake length
//   food              {on,x,y} food position
//   state             00 IDLE, 01 PLAY, 10 DEAD, 11 WIN
module snk_game_ctrl #(
    parameter int unsigned TICK_DIV  = 25_000_000,
    parameter int unsigned MAX_SCORE = 15,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic [1:0] btn_dir,
    input  logic       btn_valid,
    input  logic       btn_start,
    input  logic [6:0] snk_head,
    input  logic       snk_dead,
    output logic [1:0] snk_dir,
    output logic       snk_step,
    output logic       snk_rst,
    output logic [3:0] score,
    output logic [6:0] food,
    output logic [1:0] state
);

    localparam int unsigned    CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0]  CNT_PRE   = CW'(TICK_DIV - 2);
    localparam logic [3:0]     SCORE_MAX = 4'(MAX_SCORE);
    localparam logic [6:0]     FOOD_RST  = 7'b1_101_101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DEAD = 2'b10,
        ST_WIN  = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          step_q, step_d;
    logic          eat_chk_q, eat_chk_d;
    logic          rst_q, rst_d;
    logic [1:0]    dir_q, dir_d;
    logic [1:0]    pend_q, pend_d;
    logic [3:0]    score_q, score_d;
    logic [6:0]    food_q, food_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [1:0]    ref_dir;

    // Only the position bits of the head take part in eat/refill decisions.
    logic unused_head_on;
    assign unused_head_on = snk_head[6];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        step_d    = 1'b0;
        eat_chk_d = step_q;
        dir_d     = dir_q;
        pend_d    = pend_q;
        score_d   = score_q;
        food_d    = food_q;
        ref_dir   = dir_q;
        // x^8+x^6+x^5+x^4+1, shifting towards the MSB
        lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        case (state_q)
            ST_IDLE: begin
                if (btn_start) begin
                    state_d = ST_PLAY;
                    score_d = '0;
                    dir_d   = 2'b00;
                    pend_d  = 2'b00;
                    cnt_d   = '0;
                    food_d  = FOOD_RST;
                end
            end
            ST_PLAY: begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

                // On the step cycle the pending value is what becomes committed,
                // so a coincident button is judged against it.
                if (step_q) begin
                    ref_dir = pend_q;
                    dir_d   = pend_q;
                end
                if (btn_valid && !((btn_dir[1] == ref_dir[1]) && (btn_dir[0] != ref_dir[0])))
                    pend_d = btn_dir;

                if (snk_dead) begin
                    state_d = ST_DEAD;
                end else if (score_q == SCORE_MAX) begin
                    state_d = ST_WIN;
                end else begin
                    // Pre-decode so the registered strobe lines up with cnt==TICK_DIV-1.
                    step_d = (cnt_q == CNT_PRE);
                    if (eat_chk_q && food_q[6] && (snk_head[5:0] == food_q[5:0])) begin
                        score_d   = (score_q < SCORE_MAX) ? score_q + 4'd1 : SCORE_MAX;
                        food_d[6] = 1'b0;
                    end else if (!food_q[6] && (lfsr_q[5:0] != snk_head[5:0])) begin
                        food_d = {1'b1, lfsr_q[5:0]};
                    end
                end
            end
            default: begin
                if (btn_start)
                    state_d = ST_IDLE;
            end
        endcase

        rst_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            step_q    <= 1'b0;
            eat_chk_q <= 1'b0;
            rst_q     <= 1'b1;
            dir_q     <= 2'b00;
            pend_q    <= 2'b00;
            score_q   <= '0;
            food_q    <= FOOD_RST;
            lfsr_q    <= LFSR_SEED;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            eat_chk_q <= eat_chk_d;
            rst_q     <= rst_d;
            dir_q     <= dir_d;
            pend_q    <= pend_d;
            score_q   <= score_d;
            food_q    <= food_d;
            lfsr_q    <= lfsr_d;
        end
    end

    assign snk_dir  = dir_q;
    assign snk_step = step_q;
    assign snk_rst  = rst_q;
    assign score    = score_q;
    assign food     = food_q;
    assign state    = state_q;

endmodule

// File: tb/tb_snk_game_ctrl.sv
// tb/tb_snk_game_ctrl.sv - scoreboard bench for snk_game_ctrl
module tb_snk_game_ctrl;

    localparam int TD   = 8;
    localparam int MAXS = 2;

    logic       CLK;
    logic       rst_n;
    logic [1:0] btn_dir;
    logic       btn_valid;
    logic       btn_start;
    logic [6:0] snk_head;
    logic       snk_dead;
    logic [1:0] snk_dir;
    logic       snk_step;
    logic       snk_rst;
    logic [3:0] score;
    logic [6:0] food;
    logic [1:0] state;

    snk_game_ctrl #(
        .TICK_DIV (TD),
        .MAX_SCORE(MAXS),
        .LFSR_SEED(8'hA5)
    ) dut (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .btn_dir  (btn_dir),
        .btn_valid(btn_valid),
        .btn_start(btn_start),
        .snk_head (snk_head),
        .snk_dead (snk_dead),
        .snk_dir  (snk_dir),
        .snk_step (snk_step),
        .snk_rst  (snk_rst),
        .score    (score),
        .food     (food),
        .state    (state)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;

    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        int          cyc;
        logic [16:0] v;   // {state, step, rst, dir, score, food}
    } ev_t;
    ev_t sb_q[$];

    // Reference model: game rules in plain integer terms
    int         m_state, m_tick, m_score;
    logic [1:0] m_dir, m_pend;
    logic       m_fon, m_step, m_chk;
    logic [5:0] m_fxy;
    logic [7:0] m_lfsr;

    task automatic model_reset();
        m_state = 0; m_tick = 0; m_score = 0;
        m_dir = 2'b00; m_pend = 2'b00;
        m_fon = 1'b1; m_fxy = 6'b101_101;
        m_lfsr = 8'hA5; m_step = 1'b0; m_chk = 1'b0;
    endtask

    task automatic model_cycle(input logic st, input logic bv, input logic [1:0] bd,
                               input logic dd, input logic [6:0] hd);
        int         n_state, n_tick, n_score;
        logic [1:0] n_dir, n_pend, ref_dir;
        logic       n_fon, n_step;
        logic [5:0] n_fxy;
        ev_t        e;
        n_state = m_state; n_tick = m_tick; n_score = m_score;
        n_dir = m_dir; n_pend = m_pend; n_fon = m_fon; n_fxy = m_fxy;
        case (m_state)
            0: if (st) begin
                n_state = 1; n_score = 0; n_dir = 2'b00; n_pend = 2'b00;
                n_tick = 0; n_fon = 1'b1; n_fxy = 6'b101_101;
            end
            1: begin
                n_tick  = m_tick + 1;
                ref_dir = m_step ? m_pend : m_dir;
                if (m_step) n_dir = m_pend;
                // the reverse of a direction differs only in bit 0
                if (bv && bd != (ref_dir ^ 2'b01)) n_pend = bd;
                if (dd) n_state = 2;
                else if (m_score == MAXS) n_state = 3;
                else if (m_chk && m_fon && hd[5:0] == m_fxy) begin
                    n_score = (m_score + 1 > MAXS) ? MAXS : m_score + 1;
                    n_fon = 1'b0;
                end else if (!m_fon && m_lfsr[5:0] != hd[5:0]) begin
                    n_fon = 1'b1;
                    n_fxy = m_lfsr[5:0];
                end
            end
            default: if (st) n_state = 0;
        endcase
        n_step = (m_state == 1) && (n_state == 1) && ((n_tick % TD) == TD - 1);
        if (n_step || n_state != m_state) begin
            e.cyc = cyc_cnt + 1;
            e.v = {n_state[1:0], n_step, (n_state == 0), n_dir, n_score[3:0], n_fon, n_fxy};
            sb_q.push_back(e);
        end
        m_chk = m_step;
        m_state = n_state; m_tick = n_tick; m_score = n_score;
        m_dir = n_dir; m_pend = n_pend; m_fon = n_fon; m_fxy = n_fxy;
        m_step = n_step;
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    endtask

    task automatic tick(input logic st, input logic bv, input logic [1:0] bd,
                        input logic dd, input logic [6:0] hd);
        btn_start = st; btn_valid = bv; btn_dir = bd; snk_dead = dd; snk_head = hd;
        model_cycle(st, bv, bd, dd, hd);
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    // Advance until the model says a step (want_chk=0) or eat-check cycle (want_chk=1) is current.
    task automatic run_until(input string nm, input bit want_chk, input logic [6:0] hd);
        int n = 0;
        while (((want_chk ? m_chk : m_step) == 1'b0) && n < 4 * TD) begin
            tick(1'b0, 1'b0, 2'b00, 1'b0, hd);
            n++;
        end
        chk({"wait_", nm}, int'(want_chk ? m_chk : m_step), 1);
    endtask

    // Monitor: on every output event pop the expected record and compare
    bit          mon_en = 1'b0;
    logic [1:0]  mon_last = 2'b00;
    ev_t         mon_e;
    logic [16:0] mon_act;

    always @(negedge CLK) begin
        if (mon_en && (snk_step || state != mon_last)) begin
            total++;
            mon_act = {state, snk_step, snk_rst, snk_dir, score, food};
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_event: unexpected event at cycle %0d outputs %h", cyc_cnt, mon_act);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.cyc != cyc_cnt || mon_e.v !== mon_act) begin
                    bad++;
                    $display("FAIL sb_event: cycle %0d outputs %h, required cycle %0d outputs %h",
                             cyc_cnt, mon_act, mon_e.cyc, mon_e.v);
                end
            end
        end
        mon_last = state;
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_rst"},   int'(snk_rst), 1);
        chk({tag, "_step"},  int'(snk_step), 0);
        chk({tag, "_dir"},   int'(snk_dir), 0);
        chk({tag, "_score"}, int'(score), 0);
        chk({tag, "_food"},  int'(food), 7'h6D);
    endtask

    initial begin
        logic       st, bv, dd;
        logic [1:0] bd;
        logic [6:0] hd;
        int         r;

        rst_n = 1'b0; btn_dir = 2'b00; btn_valid = 1'b0; btn_start = 1'b0;
        snk_head = 7'h00; snk_dead = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Start: PLAY next cycle, restart released
        tick(1'b1, 1'b0, 2'b00, 1'b0, 7'h00);
        chk("start_state", int'(state), 1);
        chk("start_rst", int'(snk_rst), 0);

        // Reversal dropped, then a turn committed at the next step
        tick(1'b0, 1'b1, 2'b01, 1'b0, 7'h00);
        tick(1'b0, 1'b0, 2'b00, 1'b0, 7'h00);
        chk("dir_drop", int'(snk_dir), 0);
        tick(1'b0, 1'b1, 2'b10, 1'b0, 7'h00);
        run_until("dir_step", 1'b0, 7'h00);
        tick(1'b0, 1'b0, 2'b00, 1'b0, 7'h00);
        chk("dir_commit", int'(snk_dir), 2);

        // Eat the reset food, then refill away from the head
        run_until("eat1", 1'b1, 7'h00);
        tick(1'b0, 1'b0, 2'b00, 1'b0, 7'b1_101_101);
        chk("eat_score", int'(score), 1);
        chk("eat_food_off", int'(food[6]), 0);
        run_until("refill", 1'b0, 7'b1_101_101);
        chk("refill_on", int'(food[6]), 1);
        chk("refill_not_head", int'(food[5:0] != 6'b101_101), 1);

        // Death coincident with an eat: death wins, score unchanged
        run_until("dead_eat", 1'b1, 7'h00);
        tick(1'b0, 1'b0, 2'b00, 1'b1, {1'b1, m_fxy});
        chk("dead_state", int'(state), 2);
        chk("dead_score", int'(score), 1);
        repeat (2 * TD) tick(1'b0, 1'b0, 2'b00, 1'b0, 7'h00);
        chk("dead_hold", int'(state), 2);
        tick(1'b1, 1'b0, 2'b00, 1'b0, 7'h00);
        chk("dead_to_idle", int'(state), 0);
        chk("idle_rst", int'(snk_rst), 1);

        // Win after MAX_SCORE eats
        tick(1'b1, 1'b0, 2'b00, 1'b0, 7'h00);
        for (int k = 0; k < MAXS; k++) begin
            run_until("win_eat", 1'b1, 7'h00);
            tick(1'b0, 1'b0, 2'b00, 1'b0, {1'b1, m_fxy});
        end
        tick(1'b0, 1'b0, 2'b00, 1'b0, 7'h00);
        chk("win_state", int'(state), 3);
        chk("win_score", int'(score), MAXS);
        repeat (2 * TD) tick(1'b0, 1'b0, 2'b00, 1'b0, 7'h00);
        chk("win_hold_state", int'(state), 3);
        chk("win_hold_score", int'(score), MAXS);
        tick(1'b1, 1'b0, 2'b00, 1'b0, 7'h00);

        // Asynchronous reset right on a step cycle
        tick(1'b1, 1'b0, 2'b00, 1'b0, 7'h00);
        run_until("pre_reset", 1'b0, 7'h00);
        mon_en = 1'b0;
        sb_q.delete();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(posedge CLK);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Randomised play against the model
        for (int i = 0; i < 3000; i++) begin
            st = (m_state == 1) ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 9) == 0);
            bv = ($urandom_range(0, 4) == 0);
            bd = 2'($urandom);
            dd = (m_state == 1) && ($urandom_range(0, 199) == 0);
            r  = $urandom_range(0, 9);
            if (m_chk && r < 5)  hd = {1'b1, m_fxy};
            else if (r < 7)      hd = {1'b1, m_lfsr[5:0]};
            else                 hd = 7'($urandom);
            tick(st, bv, bd, dd, hd);
        end

        @(negedge CLK);
        #1;
        chk("sb_drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
